// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the five input FIFOs / LBDRs and one output-port arbiter.
// The master side presents requests and FIFO state; the slave side (the arbiter) returns grant and pop strobes.
interface output_port_arbiter_if #(
    parameter int NUM_IN = 5
);
    logic [NUM_IN-1:0]   req;
    logic [NUM_IN-1:0]   empty;
    logic [3*NUM_IN-1:0] flit_id;
    logic                credit_in;
    logic [NUM_IN-1:0]   grant;
    logic [NUM_IN-1:0]   rd_en;
    logic                out_valid;
    logic                credit_err;

    modport master (
        output req, empty, flit_id, credit_in,
        input  grant, rd_en, out_valid, credit_err
    );

    modport slave (
        input  req, empty, flit_id, credit_in,
        output grant, rd_en, out_valid, credit_err
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Per-output-port switch allocator: round-robin grant per packet, lock from HEADER to TAIL,
// and credit-gated pops of the winning input FIFO.
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b000
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module output_port_arbiter #(
    parameter int CREDITS = 4,
    parameter int NUM_IN  = 5
) (
    input logic                 clk,
    input logic                 rst,
    output_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = $clog2(NUM_IN);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [NUM_IN-1:0] grant_q, grant_nxt;
    logic [NUM_IN-1:0] eligible;
    logic [NUM_IN-1:0] rd_en;
    logic [PW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]     winner, owner;
    logic [2:0]        owner_flit;
    logic [CW-1:0]     credits, credits_nxt;
    logic              credit_err, err_nxt;
    logic              xfer, tail_pop;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = bus.req[i] & ~bus.empty[i] & (bus.flit_id[3*i +: 3] == `HEADER);
        end
    end

    // Descending scan so the last hit is the closest eligible input at or after rr_ptr.
    always_comb begin : rr_search
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (eligible[idx]) winner = PW'(idx);
        end
    end

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) owner = PW'(i);
        end
        owner_flit = bus.flit_id[3*int'(owner) +: 3];
    end

    assign rd_en    = grant_q & ~bus.empty & {NUM_IN{credits != '0}};
    assign xfer     = |rd_en;
    assign tail_pop = xfer && (owner_flit == `TAIL);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_nxt = {{(NUM_IN-1){1'b0}}, 1'b1} << winner;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                // Lock ignores req: LBDR drops it whenever the winner's FIFO runs dry.
                if (tail_pop) begin
                    grant_nxt  = '0;
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (owner == PW'(NUM_IN - 1)) ? '0 : owner + PW'(1);
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        credits_nxt = credits;
        err_nxt     = credit_err;
        if (xfer && !bus.credit_in) begin
            credits_nxt = credits - CW'(1);
        end else if (!xfer && bus.credit_in) begin
            if (credits == CW'(CREDITS)) err_nxt = 1'b1;
            else                          credits_nxt = credits + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            rr_ptr     <= '0;
            credits    <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_q    <= grant_nxt;
            rr_ptr     <= rr_ptr_nxt;
            credits    <= credits_nxt;
            credit_err <= err_nxt;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.rd_en      = rd_en;
    assign bus.out_valid  = xfer;
    assign bus.credit_err = credit_err;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: per-input FIFO stand-ins feed flits, expectations are hand-derived.
module tb_output_port_arbiter;
    localparam logic [2:0] FH = 3'b001;
    localparam logic [2:0] FP = 3'b000;
    localparam logic [2:0] FT = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2:0] mem [5][16];
    int         rdp [5];
    int         wrp [5];

    output_port_arbiter_if #(.NUM_IN(5)) bus ();

    output_port_arbiter #(.CREDITS(4), .NUM_IN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [2:0] f);
        mem[i][wrp[i] % 16] = f;
        wrp[i]++;
    endtask

    task automatic refresh();
        for (int i = 0; i < 5; i++) begin
            bus.empty[i]          = (rdp[i] == wrp[i]);
            bus.req[i]            = (rdp[i] != wrp[i]);
            bus.flit_id[3*i +: 3] = mem[i][rdp[i] % 16];
        end
    endtask

    task automatic apply();
        refresh();
        #1;
    endtask

    // One clock: pop whatever the DUT strobed, drop credit_in, land at negedge+1 with settled outputs.
    task automatic cycle();
        logic [4:0] rd;
        rd = bus.rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) if (rd[i]) rdp[i]++;
        bus.credit_in = 1'b0;
        refresh();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.credit_in = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdp[i] = 0;
            wrp[i] = 0;
        end
        refresh();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            rdp[i] = 0;
            wrp[i] = 0;
            for (int j = 0; j < 16; j++) mem[i][j] = FP;
        end
        bus.credit_in = 1'b0;
        refresh();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_rd_en", 32'(bus.rd_en), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_credit_err", 32'(bus.credit_err), 32'h0);
        check("rst_credits", 32'(dut.credits), 32'd4);
        rst = 1'b1;

        // 1: single 3-flit packet from N
        push(0, FH); push(0, FP); push(0, FT);
        apply();
        check("t1_idle_grant", 32'(bus.grant), 32'h0);
        check("t1_idle_rd_en", 32'(bus.rd_en), 32'h0);
        cycle();
        check("t1_grant", 32'(bus.grant), 32'h01);
        check("t1_rd_h", 32'(bus.rd_en), 32'h01);
        check("t1_valid", 32'(bus.out_valid), 32'h1);
        cycle();
        check("t1_rd_p", 32'(bus.rd_en), 32'h01);
        cycle();
        check("t1_rd_t", 32'(bus.rd_en), 32'h01);
        cycle();
        check("t1_release", 32'(bus.grant), 32'h0);
        check("t1_rd_after", 32'(bus.rd_en), 32'h0);
        check("t1_credits", 32'(dut.credits), 32'd1);
        check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // 2: round-robin between N and E
        do_reset();
        push(0, FH); push(0, FT);
        push(1, FH); push(1, FT);
        apply();
        cycle();
        check("t2_n_wins", 32'(bus.grant), 32'h01);
        cycle();
        check("t2_n_tail", 32'(bus.rd_en), 32'h01);
        cycle();
        push(0, FH); push(0, FT);
        apply();
        check("t2_gap_grant", 32'(bus.grant), 32'h0);
        check("t2_rr_ptr", 32'(dut.rr_ptr), 32'd1);
        cycle();
        check("t2_e_wins", 32'(bus.grant), 32'h02);
        cycle();
        cycle();
        check("t2_credits_zero", 32'(dut.credits), 32'd0);
        cycle();
        check("t2_n_again", 32'(bus.grant), 32'h01);
        check("t2_no_credit_rd", 32'(bus.rd_en), 32'h0);

        // 3: W empties mid-packet while S waits with a header
        do_reset();
        push(2, FH); push(2, FP);
        push(3, FH); push(3, FP); push(3, FT);
        apply();
        cycle();
        check("t3_w_wins", 32'(bus.grant), 32'h04);
        cycle();
        check("t3_rd_p", 32'(bus.rd_en), 32'h04);
        cycle();
        check("t3_hold_grant", 32'(bus.grant), 32'h04);
        check("t3_hold_rd", 32'(bus.rd_en), 32'h0);
        check("t3_hold_valid", 32'(bus.out_valid), 32'h0);
        cycle();
        check("t3_hold_grant2", 32'(bus.grant), 32'h04);
        check("t3_hold_rd2", 32'(bus.rd_en), 32'h0);
        push(2, FP); push(2, FT);
        apply();
        check("t3_resume", 32'(bus.rd_en), 32'h04);
        cycle();
        check("t3_rd_tail", 32'(bus.rd_en), 32'h04);
        cycle();
        check("t3_released", 32'(bus.grant), 32'h0);
        cycle();
        check("t3_s_wins", 32'(bus.grant), 32'h08);
        bus.credit_in = 1'b1;
        apply();
        check("t3_s_no_credit", 32'(bus.rd_en), 32'h0);
        cycle();
        check("t3_s_pops", 32'(bus.rd_en), 32'h08);

        // 4: 6-flit packet against 4 credits
        do_reset();
        push(1, FH);
        for (int k = 0; k < 4; k++) push(1, FP);
        push(1, FT);
        apply();
        cycle();
        check("t4_grant", 32'(bus.grant), 32'h02);
        for (int k = 0; k < 4; k++) begin
            check("t4_pop", 32'(bus.rd_en), 32'h02);
            cycle();
        end
        check("t4_stall_rd", 32'(bus.rd_en), 32'h0);
        check("t4_stall_grant", 32'(bus.grant), 32'h02);
        check("t4_credits0", 32'(dut.credits), 32'd0);
        cycle();
        check("t4_stall_rd2", 32'(bus.rd_en), 32'h0);
        bus.credit_in = 1'b1;
        apply();
        check("t4_credit_cycle_rd", 32'(bus.rd_en), 32'h0);
        cycle();
        check("t4_pop5", 32'(bus.rd_en), 32'h02);
        cycle();
        check("t4_stall_rd3", 32'(bus.rd_en), 32'h0);
        bus.credit_in = 1'b1;
        apply();
        cycle();
        check("t4_pop_tail", 32'(bus.rd_en), 32'h02);
        cycle();
        check("t4_released", 32'(bus.grant), 32'h0);
        check("t4_credits_end", 32'(dut.credits), 32'd0);

        // 5: simultaneous credit and pop; overflow sets sticky error
        do_reset();
        push(0, FH); push(0, FP); push(0, FP); push(0, FT);
        apply();
        cycle();
        cycle();
        cycle();
        check("t5_credits2", 32'(dut.credits), 32'd2);
        check("t5_rd", 32'(bus.rd_en), 32'h01);
        bus.credit_in = 1'b1;
        apply();
        cycle();
        check("t5_credits_hold", 32'(dut.credits), 32'd2);
        check("t5_rd_tail", 32'(bus.rd_en), 32'h01);
        cycle();
        for (int k = 0; k < 3; k++) begin
            bus.credit_in = 1'b1;
            apply();
            cycle();
        end
        check("t5_credits_full", 32'(dut.credits), 32'd4);
        check("t5_no_err", 32'(bus.credit_err), 32'h0);
        bus.credit_in = 1'b1;
        apply();
        cycle();
        check("t5_err_set", 32'(bus.credit_err), 32'h1);
        check("t5_credits_sat", 32'(dut.credits), 32'd4);
        cycle();
        check("t5_err_sticky", 32'(bus.credit_err), 32'h1);

        // 6: asynchronous reset while locked to L
        do_reset();
        push(4, FH); push(4, FP); push(4, FP); push(4, FT);
        apply();
        cycle();
        check("t6_l_wins", 32'(bus.grant), 32'h10);
        cycle();
        check("t6_rd", 32'(bus.rd_en), 32'h10);
        rst = 1'b0;
        #1;
        check("t6_async_grant", 32'(bus.grant), 32'h0);
        check("t6_async_credits", 32'(dut.credits), 32'd4);
        check("t6_async_rr", 32'(dut.rr_ptr), 32'd0);
        check("t6_async_rd", 32'(bus.rd_en), 32'h0);
        check("t6_async_valid", 32'(bus.out_valid), 32'h0);
        push(0, FH); push(0, FT);
        rst = 1'b1;
        apply();
        check("t6_post_idle", 32'(bus.grant), 32'h0);
        cycle();
        check("t6_fresh_arb", 32'(bus.grant), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
